// File: rtl/root_stage_sequencer_if.sv
// Hub FIFO link between the root sequencer and the leaf stage controllers:
// a broadcast command stream out and one status stream per leaf in.
interface root_stage_sequencer_if #(
  parameter int unsigned NUM_LEAVES     = 2,
  parameter int unsigned HUB_FIFO_WIDTH = 16
);
  logic [HUB_FIFO_WIDTH-1:0]            cmd_out_data;
  logic                                 cmd_out_valid;
  logic                                 cmd_out_ready;
  logic [NUM_LEAVES*HUB_FIFO_WIDTH-1:0] status_in_data;
  logic [NUM_LEAVES-1:0]                status_in_valid;
  logic [NUM_LEAVES-1:0]                status_in_ready;

  modport master (
    output cmd_out_data,
    output cmd_out_valid,
    input  cmd_out_ready,
    input  status_in_data,
    input  status_in_valid,
    output status_in_ready
  );

  modport slave (
    input  cmd_out_data,
    input  cmd_out_valid,
    output cmd_out_ready,
    output status_in_data,
    output status_in_valid,
    input  status_in_ready
  );
endinterface

// File: rtl/root_stage_sequencer.sv
// Root stage sequencer: broadcasts stage opcodes to all leaves, collects one
// STATUS word per leaf per phase and decides spread/sync/grow/result/abort.
module root_stage_sequencer #(
  parameter int unsigned NUM_LEAVES              = 2,
  parameter int unsigned HUB_FIFO_WIDTH          = 16,
  parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
  parameter int unsigned MAX_ITERATIONS          = 255,
  parameter int unsigned TIMEOUT_CYCLES          = 4096
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  root_stage_sequencer_if.master             hub,
  output logic                               busy,
  output logic                               result_valid,
  output logic                               deadlock,
  output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  output logic [31:0]                        cycle_counter
);

  localparam int unsigned W  = HUB_FIFO_WIDTH;
  localparam int unsigned IW = ITERATION_COUNTER_WIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LP_TIMEOUT = TW'(TIMEOUT_CYCLES);
  localparam logic [IW:0]   LP_MAX_IT  = (IW + 1)'(MAX_ITERATIONS);
  localparam logic [2:0]    OP_STATUS  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_COLLECT_SPREAD,
    S_COLLECT_SYNC
  } state_t;

  state_t                r_state;
  state_t                r_ret_state;
  logic                  r_cmd_valid;
  logic [W-1:0]          r_cmd_data;
  logic                  r_result_pending;
  logic                  r_result_valid;
  logic                  r_deadlock;
  logic [IW-1:0]         r_iter;
  logic [31:0]           r_cycle;
  logic [NUM_LEAVES-1:0] r_received;
  logic                  r_acc_fly;
  logic                  r_acc_odd;
  logic [TW-1:0]         r_timer;

  logic                  w_collect;
  logic [NUM_LEAVES-1:0] w_ready;
  logic [NUM_LEAVES-1:0] w_take;
  logic                  w_fly;
  logic                  w_odd;
  logic [TW-1:0]         w_timer_inc;
  logic                  w_timeout;
  logic                  w_all_rcv;
  logic [IW:0]           w_iter_inc;
  logic                  w_below_max;

  function automatic logic [W-1:0] f_cmd(input logic [2:0] op);
    logic [W-1:0] v;
    v      = '0;
    v[2:0] = op;
    return v;
  endfunction

  always_comb begin
    w_collect = (r_state == S_COLLECT_SPREAD) || (r_state == S_COLLECT_SYNC);
    w_ready   = w_collect ? ~r_received : '0;
    w_take    = '0;
    w_fly     = 1'b0;
    w_odd     = 1'b0;
    // Non-STATUS words are consumed but never mark the leaf as reported.
    for (int unsigned i = 0; i < NUM_LEAVES; i++) begin
      w_take[i] = hub.status_in_valid[i] && w_ready[i] &&
                  (hub.status_in_data[i*W +: 3] == OP_STATUS);
      w_fly = w_fly | (w_take[i] & hub.status_in_data[i*W + 3]);
      w_odd = w_odd | (w_take[i] & hub.status_in_data[i*W + 4]);
    end
    w_timer_inc = r_timer + 1'b1;
    w_timeout   = (w_timer_inc >= LP_TIMEOUT);
    w_all_rcv   = &r_received;
    w_iter_inc  = {1'b0, r_iter} + 1'b1;
    w_below_max = (w_iter_inc < LP_MAX_IT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_ret_state      <= S_IDLE;
      r_cmd_valid      <= 1'b0;
      r_cmd_data       <= '0;
      r_result_pending <= 1'b0;
      r_result_valid   <= 1'b0;
      r_deadlock       <= 1'b0;
      r_iter           <= '0;
      r_cycle          <= '0;
      r_received       <= '0;
      r_acc_fly        <= 1'b0;
      r_acc_odd        <= 1'b0;
      r_timer          <= '0;
    end else begin
      r_result_valid <= 1'b0;
      if ((r_state != S_IDLE) && (r_cycle != '1)) begin
        r_cycle <= r_cycle + 32'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_iter           <= '0;
            r_deadlock       <= 1'b0;
            r_cycle          <= 32'd1;
            r_state          <= S_SEND;
            r_ret_state      <= S_COLLECT_SPREAD;
            r_cmd_valid      <= 1'b1;
            r_cmd_data       <= f_cmd(3'd1);
            r_result_pending <= 1'b0;
          end
        end

        S_SEND: begin
          if (hub.cmd_out_ready) begin
            r_cmd_valid      <= 1'b0;
            r_cmd_data       <= '0;
            r_state          <= r_ret_state;
            r_received       <= '0;
            r_acc_fly        <= 1'b0;
            r_acc_odd        <= 1'b0;
            r_timer          <= '0;
            r_result_valid   <= r_result_pending;
            r_result_pending <= 1'b0;
          end
        end

        S_COLLECT_SPREAD, S_COLLECT_SYNC: begin
          r_timer    <= w_timer_inc;
          r_received <= r_received | w_take;
          r_acc_fly  <= r_acc_fly | w_fly;
          r_acc_odd  <= r_acc_odd | w_odd;
          // Timeout wins over an evaluation that falls on the same cycle.
          if (w_timeout) begin
            r_deadlock  <= 1'b1;
            r_state     <= S_SEND;
            r_ret_state <= S_IDLE;
            r_cmd_valid <= 1'b1;
            r_cmd_data  <= f_cmd((r_state == S_COLLECT_SPREAD) ? 3'd2 : 3'd3);
          end else if (w_all_rcv) begin
            if (r_state == S_COLLECT_SPREAD) begin
              if (r_acc_fly) begin
                r_received <= '0;
                r_acc_fly  <= 1'b0;
                r_acc_odd  <= 1'b0;
              end else begin
                r_state     <= S_SEND;
                r_ret_state <= S_COLLECT_SYNC;
                r_cmd_valid <= 1'b1;
                r_cmd_data  <= f_cmd(3'd1);
              end
            end else if (r_acc_odd && w_below_max) begin
              r_iter      <= w_iter_inc[IW-1:0];
              r_state     <= S_SEND;
              r_ret_state <= S_COLLECT_SPREAD;
              r_cmd_valid <= 1'b1;
              r_cmd_data  <= f_cmd(3'd1);
            end else if (r_acc_odd) begin
              r_deadlock  <= 1'b1;
              r_state     <= S_SEND;
              r_ret_state <= S_IDLE;
              r_cmd_valid <= 1'b1;
              r_cmd_data  <= f_cmd(3'd3);
            end else begin
              r_state          <= S_SEND;
              r_ret_state      <= S_IDLE;
              r_cmd_valid      <= 1'b1;
              r_cmd_data       <= f_cmd(3'd2);
              r_result_pending <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hub.cmd_out_valid   = r_cmd_valid;
  assign hub.cmd_out_data    = r_cmd_data;
  assign hub.status_in_ready = w_ready;
  assign busy                = (r_state != S_IDLE);
  assign result_valid        = r_result_valid;
  assign deadlock            = r_deadlock;
  assign iteration_counter   = r_iter;
  assign cycle_counter       = r_cycle;

endmodule

// File: tb/tb_root_stage_sequencer.sv
// Directed bench for root_stage_sequencer: expected broadcast opcodes are queued
// as stimulus is driven and checked at each command handshake.
module tb_root_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        result_valid;
  logic        deadlock;
  logic [7:0]  iteration_counter;
  logic [31:0] cycle_counter;

  root_stage_sequencer_if #(.NUM_LEAVES(2), .HUB_FIFO_WIDTH(16)) hub_if ();

  root_stage_sequencer #(
    .NUM_LEAVES              (2),
    .HUB_FIFO_WIDTH          (16),
    .ITERATION_COUNTER_WIDTH (8),
    .MAX_ITERATIONS          (3),
    .TIMEOUT_CYCLES          (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .hub               (hub_if.master),
    .busy              (busy),
    .result_valid      (result_valid),
    .deadlock          (deadlock),
    .iteration_counter (iteration_counter),
    .cycle_counter     (cycle_counter)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_hs   = 0;
  int          n_rv   = 0;
  int          n_busy = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sw(input logic fly, input logic odd);
    return {11'b0, odd, fly, 3'd5};
  endfunction

  // Handshake monitor: inputs only change just after posedge, so the
  // negedge value of valid&&ready is what the next edge will see.
  always @(negedge clk) begin
    if (!reset && hub_if.cmd_out_valid && hub_if.cmd_out_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", {48'b0, hub_if.cmd_out_data}, 64'hFFFF);
      end else begin
        chk("cmd_opcode", {48'b0, hub_if.cmd_out_data}, {48'b0, exp_q.pop_front()});
      end
    end
    if (result_valid) n_rv++;
    if (busy) n_busy++;
  end

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_q();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("cmd_drain", exp_q.size(), 0);
  endtask

  task automatic leaf_report(input logic f0, input logic o0, input logic f1, input logic o1);
    logic [1:0] pend;
    logic [1:0] acc;
    pend = 2'b11;
    hub_if.status_in_data = {sw(f1, o1), sw(f0, o0)};
    for (int k = 0; k < 40; k++) begin
      hub_if.status_in_valid = pend;
      acc = pend & hub_if.status_in_ready;
      tick();
      pend = pend & ~acc;
      if (pend == 2'b00) break;
    end
    hub_if.status_in_valid = 2'b00;
    chk("leaf_report_done", pend, 2'b00);
  endtask

  initial begin
    int hs0;
    int n;
    reset = 1'b1;
    start = 1'b0;
    hub_if.cmd_out_ready   = 1'b1;
    hub_if.status_in_valid = 2'b00;
    hub_if.status_in_data  = '0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", hub_if.cmd_out_valid, 0);
    chk("rst_cmd_data", hub_if.cmd_out_data, 0);
    chk("rst_status_ready", hub_if.status_in_ready, 0);
    chk("rst_deadlock", deadlock, 0);
    chk("rst_iter", iteration_counter, 0);
    chk("rst_cycle", cycle_counter, 0);

    // Plain round: start, spread clean, sync clean, result.
    n_rv = 0;
    n_busy = 0;
    exp_q.push_back(16'd1);
    pulse_start();
    chk("t1_cmd_valid_after_start", hub_if.cmd_out_valid, 1);
    wait_q();
    exp_q.push_back(16'd1);
    leaf_report(0, 0, 0, 0);
    wait_q();
    exp_q.push_back(16'd2);
    leaf_report(0, 0, 0, 0);
    wait_q();
    repeat (3) tick();
    chk("t1_result_pulses", n_rv, 1);
    chk("t1_iter", iteration_counter, 0);
    chk("t1_deadlock", deadlock, 0);
    chk("t1_idle", busy, 0);
    chk("t1_cycle", cycle_counter, n_busy + 1);

    // Grow: leaf0 odd in sync, then all-even sync finishes.
    n_rv = 0;
    exp_q.push_back(16'd1);
    pulse_start();
    wait_q();
    exp_q.push_back(16'd1);
    leaf_report(0, 0, 0, 0);
    wait_q();
    exp_q.push_back(16'd1);
    leaf_report(0, 1, 0, 0);
    wait_q();
    chk("t2_iter_after_grow", iteration_counter, 1);
    chk("t2_back_to_spread_ready", hub_if.status_in_ready, 2'b11);
    exp_q.push_back(16'd1);
    leaf_report(0, 0, 0, 0);
    wait_q();
    exp_q.push_back(16'd2);
    leaf_report(0, 0, 0, 0);
    wait_q();
    repeat (2) tick();
    chk("t2_iter_final", iteration_counter, 1);
    chk("t2_result_pulses", n_rv, 1);

    // Spread with a message flying: re-collect, then one command.
    exp_q.push_back(16'd1);
    pulse_start();
    wait_q();
    hs0 = n_hs;
    leaf_report(0, 0, 1, 0);
    repeat (3) tick();
    chk("t3_no_cmd_on_flying", n_hs, hs0);
    chk("t3_recollect_ready", hub_if.status_in_ready, 2'b11);
    exp_q.push_back(16'd1);
    leaf_report(0, 0, 0, 0);
    wait_q();
    repeat (3) tick();
    chk("t3_single_cmd", n_hs, hs0 + 1);
    exp_q.push_back(16'd2);
    leaf_report(0, 0, 0, 0);
    wait_q();
    tick();

    // Backpressure on the start command for 5 cycles.
    hub_if.cmd_out_ready = 1'b0;
    hs0 = n_hs;
    exp_q.push_back(16'd1);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", hub_if.cmd_out_valid, 1);
      chk("t4_hold_data", hub_if.cmd_out_data, 16'd1);
      tick();
    end
    hub_if.cmd_out_ready = 1'b1;
    wait_q();
    chk("t4_one_handshake", n_hs, hs0 + 1);

    // Timeout: leaf1 silent in sync; abort after 16 collect cycles.
    exp_q.push_back(16'd1);
    leaf_report(0, 0, 0, 0);
    wait_q();
    exp_q.push_back(16'd3);
    hub_if.status_in_data  = {sw(0, 0), sw(0, 0)};
    hub_if.status_in_valid = 2'b01;
    n = 0;
    while (!hub_if.cmd_out_valid && n < 40) begin
      tick();
      n++;
    end
    hub_if.status_in_valid = 2'b00;
    chk("t5_timeout_cycles", n, 16);
    wait_q();
    tick();
    chk("t5_deadlock", deadlock, 1);
    chk("t5_idle", busy, 0);

    // Next start clears deadlock; then run into the iteration limit (3).
    exp_q.push_back(16'd1);
    pulse_start();
    chk("t6_deadlock_cleared", deadlock, 0);
    wait_q();
    for (int g = 0; g < 2; g++) begin
      exp_q.push_back(16'd1);
      leaf_report(0, 0, 0, 0);
      wait_q();
      exp_q.push_back(16'd1);
      leaf_report(0, 0, 0, 1);
      wait_q();
    end
    chk("t6_iter_before_limit", iteration_counter, 2);
    exp_q.push_back(16'd1);
    leaf_report(0, 0, 0, 0);
    wait_q();
    exp_q.push_back(16'd3);
    leaf_report(0, 1, 0, 1);
    wait_q();
    tick();
    chk("t6_limit_deadlock", deadlock, 1);
    chk("t6_limit_iter", iteration_counter, 2);
    chk("t6_limit_idle", busy, 0);

    // Non-STATUS word dropped, duplicate STATUS ignored.
    exp_q.push_back(16'd1);
    pulse_start();
    wait_q();
    hub_if.status_in_data  = {sw(0, 0), 16'h000C};
    hub_if.status_in_valid = 2'b01;
    tick();
    chk("t7_nonstatus_dropped", hub_if.status_in_ready, 2'b11);
    hub_if.status_in_data = {sw(0, 0), sw(0, 0)};
    tick();
    chk("t7_status_accepted", hub_if.status_in_ready, 2'b10);
    hub_if.status_in_data = {sw(0, 0), sw(1, 1)};
    repeat (2) tick();
    chk("t7_dup_ignored", hub_if.status_in_ready, 2'b10);
    exp_q.push_back(16'd1);
    hub_if.status_in_data  = {sw(0, 0), sw(0, 0)};
    hub_if.status_in_valid = 2'b10;
    tick();
    hub_if.status_in_valid = 2'b00;
    wait_q();

    // Reset in the middle of a sync collect.
    hub_if.status_in_data  = {sw(0, 0), sw(0, 1)};
    hub_if.status_in_valid = 2'b01;
    tick();
    hub_if.status_in_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t8_busy", busy, 0);
    chk("t8_cmd_valid", hub_if.cmd_out_valid, 0);
    chk("t8_cmd_data", hub_if.cmd_out_data, 0);
    chk("t8_status_ready", hub_if.status_in_ready, 0);
    chk("t8_result_valid", result_valid, 0);
    chk("t8_deadlock", deadlock, 0);
    chk("t8_iter", iteration_counter, 0);
    chk("t8_cycle", cycle_counter, 0);
    repeat (2) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/root_stage_sequencer.md
Name: root_stage_sequencer

Overview:
- Hub-side master that drives the per-leaf decoder stage controllers over the hub FIFO link.
- Broadcasts 3-bit stage opcodes on one command stream and collects one status word per leaf per phase.
- Decides each transition:
  - spread to sync;
  - sync to grow (next iteration);
  - sync to result;
  - abort to idle.
- Reports iteration count, cycle count, result-valid and deadlock to the host.

Parameters:
- NUM_LEAVES, 2, number of leaf controllers fed by the broadcast and reporting status.
- HUB_FIFO_WIDTH, 16, width of command and status words.
- ITERATION_COUNTER_WIDTH, 8, iteration counter width.
- MAX_ITERATIONS, 255, iteration limit; reaching it forces abort.
- TIMEOUT_CYCLES, 4096, maximum cycles in one collect phase before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a decoding round (ignored unless IDLE)
- cmd_out_data  out  HUB_FIFO_WIDTH  broadcast command; [2:0] opcode, other bits 0
- cmd_out_valid  out  1  command valid
- cmd_out_ready  in  1  downstream hub FIFO not full
- status_in_data  in  NUM_LEAVES*HUB_FIFO_WIDTH  leaf i word at [i*W +: W]; [2:0]=3'd5 STATUS, [3] has_message_flying, [4] has_odd_clusters
- status_in_valid  in  NUM_LEAVES  per-leaf valid
- status_in_ready  out  NUM_LEAVES  per-leaf ready
- busy  out  1  state != IDLE
- result_valid  out  1  one-cycle pulse: round finished normally
- deadlock  out  1  sticky: timeout or iteration limit; cleared by next accepted start
- iteration_counter  out  ITERATION_COUNTER_WIDTH  completed grow iterations this round
- cycle_counter  out  32  cycles since start; frozen after finish/abort

Behaviour:
- Opcodes are fixed by the leaf controller.
  - In leaf IDLE: 1 = start.
  - In leaf SPREAD: 1 = to sync, 2 = abort.
  - In leaf SYNC: 1 = grow, 2 = result, 3 = abort.
- States: IDLE, SEND, COLLECT_SPREAD, COLLECT_SYNC.
- SEND holds a pending opcode and a return state.
- Reset: state=IDLE, cmd_out_valid=0, cmd_out_data=0, status_in_ready=0, result_valid=0, deadlock=0, iteration_counter=0, cycle_counter=0, received bitmap=0, both flag accumulators=0.
- IDLE + start:
  - clear iteration_counter and deadlock; cycle_counter<=1;
  - enter SEND with opcode 1, return COLLECT_SPREAD;
  - cmd_out_valid is high the cycle after start.
- SEND:
  - cmd_out_valid=1 with stable data until cmd_out_ready sampled high;
  - on the handshake cycle: valid drops next cycle; go to return state; clear bitmap, accumulators and phase timer.
- COLLECT_*:
  - status_in_ready[i] = !received[i].
  - On valid&&ready from leaf i: set received[i].
    - If opcode == 5, OR bit3/bit4 into the accumulators.
    - Otherwise drop the word, leave received[i] clear, and keep ready high.
  - Multiple leaves can be accepted in the same cycle.
  - A word arriving on the same cycle that completes the bitmap is included in the evaluation.
  - Evaluation happens the cycle after the bitmap is all ones.
- COLLECT_SPREAD evaluation:
  - any message flying: clear bitmap and accumulators, stay (re-collect);
  - else: SEND opcode 1, return COLLECT_SYNC.
- COLLECT_SYNC evaluation:
  - any odd cluster and iteration_counter+1 < MAX_ITERATIONS: iteration_counter++, SEND opcode 1, return COLLECT_SPREAD;
  - any odd cluster at the limit: deadlock<=1, SEND opcode 3, return IDLE;
  - no odd cluster: SEND opcode 2, return IDLE; result_valid pulses on the handshake cycle.
- Timeout:
  - the phase timer counts every COLLECT cycle;
  - when it reaches TIMEOUT_CYCLES: deadlock<=1, SEND abort (opcode 2 from SPREAD, 3 from SYNC), return IDLE.
  - Timeout takes priority over an evaluation in the same cycle.
- cycle_counter increments every non-IDLE cycle and saturates at 2^32-1.
- start while busy is ignored.
- reset mid-operation returns all outputs to their reset values the next cycle. Any partially accepted status is discarded.

Test Plan:
- NUM_LEAVES=2, start; no backpressure:
  - cmd opcode 1 issued.
  - Both leaves report {flying=0, odd=0} → opcode 1, then both report {0,0} → opcode 2.
  - result_valid one pulse, iteration_counter=0, deadlock=0.
- Sync round, leaf0 odd=1, leaf1 odd=0:
  - opcode 1 (grow), iteration_counter=1, state returns to COLLECT_SPREAD.
  - Second sync all-even → opcode 2, iteration_counter=1.
- Spread round, leaf1 flying=1:
  - no command issued; re-collect.
  - Next all-zero round → opcode 1 sent exactly once.
- cmd_out_ready low for 5 cycles during SEND:
  - cmd_out_valid and data stable for all 5 cycles; exactly one handshake.
- TIMEOUT_CYCLES=16, leaf1 silent in COLLECT_SYNC:
  - after 16 cycles opcode 3 issued, deadlock=1, state IDLE.
  - Next start clears deadlock.
- Leaf0 sends a non-STATUS word, then a duplicate STATUS:
  - first word dropped with ready high;
  - second word accepted, then ready stays low until the phase ends.
  - Separately: reset asserted mid-COLLECT → all outputs return to reset values.
